// File: rtl/uart_pkg.sv
// Shared types for the streaming UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state and per-word parity sense.
package uart_pkg;

    localparam int MAX_WORD_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

    // Word field is sized for the widest legal word; narrower
    // configurations zero-extend and the unused bits are pruned.
    typedef struct packed {
        logic [8*MAX_WORD_BYTES-1:0] word;
        logic                        big_endian;
`ifdef UART_TX_PARITY_EN
        logic                        parity_odd;
`endif
    } fifo_entry_t;

    function automatic int baud_ticks(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty/level.
// Used by uart_tx_stream (see UART_TX_PARITY_EN there).
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     push,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_chk
            $error("uart_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Word-stream UART transmitter: FIFO of words, serialized byte by byte.
// Define UART_TX_PARITY_EN for 8-bit + parity frames; default is 8N1.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 250_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int WORD_BYTES  = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [8*WORD_BYTES-1:0]       data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic                          big_endian,
`ifdef UART_TX_PARITY_EN
    input  logic                          parity_odd,
`endif
    output logic                          tx_line,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BAUD_TICKS = baud_ticks(CLK_FREQ_HZ, BAUD_RATE);
    localparam int TW = $clog2(BAUD_TICKS);

    generate
        if (BAUD_TICKS < 2) begin : g_baud_chk
            $error("uart_tx_stream: BAUD_TICKS must be >= 2");
        end
        if (WORD_BYTES < 1 || WORD_BYTES > MAX_WORD_BYTES) begin : g_wb_chk
            $error("uart_tx_stream: WORD_BYTES must be 1..8");
        end
    endgenerate

    fifo_entry_t wr_entry;
    fifo_entry_t rd_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    always_comb begin
        wr_entry = '0;
        wr_entry.word = (8*MAX_WORD_BYTES)'(data_in);
        wr_entry.big_endian = big_endian;
`ifdef UART_TX_PARITY_EN
        wr_entry.parity_odd = parity_odd;
`endif
    end

    assign data_ready = !fifo_full;

    uart_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (wr_entry),
        .push    (data_valid),
        .pop     (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    function automatic logic [7:0] pick_byte(input fifo_entry_t e,
                                             input logic [2:0] idx);
        logic [2:0] pos;
        pos = e.big_endian ? 3'(WORD_BYTES - 1) - idx : idx;
        return e.word[8*pos +: 8];
    endfunction

    tx_state_t   state;
    tx_state_t   state_nxt;
    fifo_entry_t cur;
    logic [7:0]  cur_byte;
    logic [TW-1:0] tick;
    logic [2:0]  bit_idx;
    logic [2:0]  byte_idx;
    logic        bit_end;
    logic        last_byte;
    logic        tx_d;

    assign bit_end   = (tick == TW'(BAUD_TICKS - 1));
    assign last_byte = (byte_idx == 3'(WORD_BYTES - 1));
    assign busy      = !fifo_empty || (state != ST_IDLE);

    // tx_line is registered so the pin never glitches on state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tx_line <= 1'b1;
        end else begin
            state   <= state_nxt;
            tx_line <= tx_d;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_START;
                    pop       = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (!last_byte) begin
                        state_nxt = ST_START;
                    end else if (!fifo_empty) begin
                        state_nxt = ST_START;
                        pop       = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = cur_byte[bit_idx];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = (^cur_byte) ^ cur.parity_odd;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= '0;
            cur_byte <= '0;
            tick     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else begin
            if (state == ST_IDLE || bit_end) begin
                tick <= '0;
            end else begin
                tick <= tick + TW'(1);
            end
            if (state == ST_DATA && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (pop) begin
                cur      <= rd_entry;
                byte_idx <= '0;
                cur_byte <= pick_byte(rd_entry, 3'd0);
            end else if (state == ST_STOP && bit_end && !last_byte) begin
                byte_idx <= byte_idx + 3'd1;
                cur_byte <= pick_byte(cur, byte_idx + 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench for uart_tx_stream: a line decoder checks frames
// against bytes predicted from each accepted word (UART_TX_PARITY_EN aware).
module tb_uart_tx_stream;

    localparam int BT    = 10;
    localparam int WB    = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = BT * NB;
    localparam int WORD_T = WB * FRAME;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        big_endian = 1'b0;
    logic        parity_odd = 1'b0;
    logic        data_ready;
    logic        tx_line;
    logic        busy;
    logic [2:0]  fifo_level;

    uart_tx_stream #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD_RATE   (100_000),
        .WORD_BYTES  (WB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .big_endian (big_endian),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .tx_line    (tx_line),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b;
        logic       par;
    } exp_t;

    exp_t exp_q[$];
    int   start_q[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Reference: bytes in wire order with their parity bit.
    task automatic model_push(input logic [31:0] w, input logic be,
                              input logic po);
        for (int i = 0; i < WB; i++) begin
            int   k;
            exp_t e;
            k = be ? (WB - 1 - i) : i;
            e.b = 8'((w >> (8 * k)) & 32'hFF);
            e.par = logic'($countones(e.b) % 2) ^ po;
            exp_q.push_back(e);
        end
    endtask

    task automatic frame_done(input logic [NB-1:0] f);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte %0h expected none",
                     f[8:1]);
            return;
        end
        e = exp_q.pop_front();
        check("start_bit", 64'(f[0]), 64'(0));
        check("data_byte", 64'(f[8:1]), 64'(e.b));
`ifdef UART_TX_PARITY_EN
        check("parity_bit", 64'(f[9]), 64'(e.par));
`endif
        check("stop_bit", 64'(f[NB-1]), 64'(1));
    endtask

    // Line decoder: mid-bit sampling from the first low cycle.
    int          mc = -1;
    logic [NB-1:0] fr_bits = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mc = -1;
        end else if (mc < 0) begin
            if (tx_line === 1'b0) begin
                mc = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mc++;
            if (mc % BT == BT / 2) begin
                fr_bits[mc / BT] = tx_line;
                if (mc / BT == NB - 1) begin
                    frame_done(fr_bits);
                    mc = -1;
                end
            end
        end
    end

    task automatic push(input logic [31:0] w, input logic be,
                        input logic po, output int acc);
        int guard;
        guard = 0;
        data_in = w;
        big_endian = be;
        parity_odd = po;
        data_valid = 1'b1;
        while (data_ready !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got ready=%0b expected 1",
                     data_ready);
        end
        @(negedge clk);
        acc = cyc;
        data_valid = 1'b0;
        data_in = $urandom;
        big_endian = 1'($urandom);
        parity_odd = 1'($urandom);
        model_push(w, be, po);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0 || mc >= 0)
               && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     exp_q.size());
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e;
        int e1;
        int t;
        int lv[5];
        int rd[5];
        int gap;
        logic pre;

        repeat (3) @(negedge clk);
        check("rst_tx_line", 64'(tx_line), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(data_ready), 64'(1));
        check("rst_level", 64'(fifo_level), 64'(0));
        rst_n = 1'b1;

        // Little-endian word, first accept right after reset release.
        start_q.delete();
        push(32'h44332211, 1'b0, 1'b0, e);
        wait_cyc(e + WORD_T);
        check("busy_last_cycle", 64'(busy), 64'(1));
        wait_cyc(e + WORD_T + 1);
        check("busy_done", 64'(busy), 64'(0));
        drain();
        check("le_frames", 64'(start_q.size()), 64'(WB));
        if (start_q.size() == WB) begin
            check("first_start_latency", 64'(start_q[0] - e), 64'(2));
            for (int i = 1; i < WB; i++)
                check("le_spacing", 64'(start_q[i] - start_q[i-1]),
                      64'(FRAME));
        end

        // Big-endian word.
        push(32'h44332211, 1'b1, 1'b0, e);
        drain();

        // Five back-to-back words fill the queue behind the serializer.
        start_q.delete();
        for (int i = 0; i < 5; i++) begin
            push($urandom, 1'($urandom), 1'($urandom), t);
            if (i == 0) e1 = t;
            lv[i] = int'(fifo_level);
            rd[i] = int'(data_ready);
        end
        check("burst_level0", 64'(lv[0]), 64'(1));
        check("burst_level1", 64'(lv[1]), 64'(1));
        check("burst_level2", 64'(lv[2]), 64'(2));
        check("burst_level3", 64'(lv[3]), 64'(3));
        check("burst_level4", 64'(lv[4]), 64'(4));
        check("burst_ready3", 64'(rd[3]), 64'(1));
        check("burst_ready4", 64'(rd[4]), 64'(0));
        for (int k = 0; k < 5; k++) begin
            wait_cyc(e1 + 1 + k * WORD_T + FRAME / 2);
            check("drain_level", 64'(fifo_level), 64'(4 - k));
        end
        drain();
        check("burst_frames", 64'(start_q.size()), 64'(5 * WB));
        for (int i = 1; i < start_q.size(); i++)
            check("burst_gap", 64'(start_q[i] - start_q[i-1]), 64'(FRAME));

        // Parity sense on a word with FF and 00 bytes.
        push(32'h000000FF, 1'b0, 1'b0, e);
        push(32'h000000FF, 1'b0, 1'b1, e);
        drain();

        // Reset during bit 3 of byte 2 with two words still queued.
        push(32'hA500C3F0, 1'b0, 1'b0, e);
        push($urandom, 1'b0, 1'b0, t);
        push($urandom, 1'b1, 1'b1, t);
        wait_cyc(e + 1 + 2 * FRAME + 4 * BT + BT / 2);
        pre = tx_line;
        check("pre_reset_bit", 64'(pre), 64'(0));
        check("pre_reset_level", 64'(fifo_level), 64'(2));
        rst_n = 1'b0;
        #1;
        check("abort_tx_line", 64'(tx_line), 64'(1));
        check("abort_level", 64'(fifo_level), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_ready", 64'(data_ready), 64'(1));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(32'h5A3C0F81, 1'b1, 1'b1, e);
        drain();

        // Randomized words with random spacing.
        for (int i = 0; i < 12; i++) begin
            push($urandom, 1'($urandom), 1'($urandom), t);
            gap = $urandom_range(0, 30);
            repeat (gap) @(negedge clk);
        end
        drain();

        check("leftover_bytes", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
